// File: rtl/cache_pkg.sv
// Shared definitions for the cache line fetch path: fetch engine states,
// fetch command encodings and the memory write priority used by fills.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_RD     = 3'd1,
    WB_WR     = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_DATA = 3'd4,
    FILL_WR   = 3'd5,
    DONE      = 3'd6
  } fetch_state_e;

  localparam logic [1:0] FETCH_NOP     = 2'b00;
  localparam logic [1:0] FETCH_FILL    = 2'b01;
  localparam logic [1:0] FETCH_WB_FILL = 2'b10;

  localparam logic [1:0] WPRI_FILL = 2'b10;
  localparam logic [1:0] WPRI_NONE = 2'b00;

endpackage

// File: rtl/line_fetch_engine.sv
// Line fetch engine: moves one cache line between the local line memory and
// the downstream bus. An optional writeback of the victim line is done word by
// word first, then the new line is fetched word by word into the same slot.
module line_fetch_engine
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              fetch_req,
  output logic                                              fetch_gnt,
  input  logic [1:0]                                        fetch_cmd,
  input  logic [$clog2(list_depth)-1:0]                     fetch_tag,
  input  logic [addr_width-1:0]                             fetch_addr,
  input  logic [addr_width-1:0]                             fetch_addr_pre,
  output logic                                              fetch_done,
  output logic                                              mem_ren,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0]  mem_raddr,
  input  logic [data_width-1:0]                             mem_rdata,
  output logic                                              mem_wen,
  input  logic                                              mem_wready,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0]  mem_waddr,
  output logic [data_width-1:0]                             mem_wdata,
  output logic [1:0]                                        mem_wpri,
  output logic                                              bus_rd_req,
  input  logic                                              bus_rd_gnt,
  output logic [addr_width-1:0]                             bus_rd_addr,
  input  logic                                              bus_rd_valid,
  input  logic [data_width-1:0]                             bus_rd_data,
  output logic                                              bus_wr_req,
  input  logic                                              bus_wr_gnt,
  output logic [addr_width-1:0]                             bus_wr_addr,
  output logic [data_width-1:0]                             bus_wr_data
);

  localparam int TAG_W = $clog2(list_depth);
  localparam int CNT_W = $clog2(list_width);
  localparam int BYTES = data_width / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(list_width - 1);

  fetch_state_e            state_q;
  logic [1:0]              cmd_q;
  logic [TAG_W-1:0]        tag_q;
  logic [addr_width-1:0]   fillAddr_q;
  logic [addr_width-1:0]   victimAddr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [data_width-1:0]   wbWord_q;
  logic [data_width-1:0]   fillWord_q;
  logic                    wbFirst_q;
  logic [addr_width-1:0]   byteOff;
  logic [data_width-1:0]   wbWord;

  // Byte offset of the current word within the line; wraps naturally with the address width.
  assign byteOff = addr_width'(cnt_q) * addr_width'(BYTES);

  // The line memory word arrives in the first writeback-write cycle, so it is passed through
  // directly then and the captured copy is used while the bus keeps us waiting.
  assign wbWord = wbFirst_q ? mem_rdata : wbWord_q;

  // Output decode from the registered state; everything idles at zero outside its own state.
  always_comb begin
    fetch_gnt   = rst_n && (state_q == IDLE);
    fetch_done  = (state_q == DONE);
    mem_ren     = (state_q == WB_RD);
    mem_raddr   = (state_q == WB_RD) ? {tag_q, cnt_q} : '0;
    mem_wen     = (state_q == FILL_WR);
    mem_waddr   = (state_q == FILL_WR) ? {tag_q, cnt_q} : '0;
    mem_wdata   = (state_q == FILL_WR) ? fillWord_q : '0;
    mem_wpri    = (state_q == FILL_WR) ? WPRI_FILL : WPRI_NONE;
    bus_rd_req  = (state_q == FILL_REQ);
    bus_rd_addr = (state_q == FILL_REQ) ? fillAddr_q + byteOff : '0;
    bus_wr_req  = (state_q == WB_WR);
    bus_wr_addr = (state_q == WB_WR) ? victimAddr_q + byteOff : '0;
    bus_wr_data = (state_q == WB_WR) ? wbWord : '0;
  end

  // Fetch sequencer: accepts a command, walks the victim line out, then walks the new line in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      tag_q        <= '0;
      fillAddr_q   <= '0;
      victimAddr_q <= '0;
      cnt_q        <= '0;
      wbWord_q     <= '0;
      fillWord_q   <= '0;
      wbFirst_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            cmd_q        <= fetch_cmd;
            tag_q        <= fetch_tag;
            fillAddr_q   <= fetch_addr;
            victimAddr_q <= fetch_addr_pre;
            cnt_q        <= '0;
            case (fetch_cmd)
              FETCH_WB_FILL: state_q <= WB_RD;
              FETCH_NOP:     state_q <= DONE;
              default:       state_q <= FILL_REQ;
            endcase
          end
        end
        WB_RD: begin
          wbFirst_q <= 1'b1;
          state_q   <= WB_WR;
        end
        WB_WR: begin
          if (wbFirst_q) begin
            wbWord_q  <= mem_rdata;
            wbFirst_q <= 1'b0;
          end
          if (bus_wr_gnt) begin
            wbFirst_q <= 1'b0;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= (cmd_q == FETCH_WB_FILL) ? FILL_REQ : DONE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= WB_RD;
            end
          end
        end
        FILL_REQ: begin
          if (bus_rd_gnt) state_q <= FILL_DATA;
        end
        FILL_DATA: begin
          if (bus_rd_valid) begin
            fillWord_q <= bus_rd_data;
            state_q    <= FILL_WR;
          end
        end
        FILL_WR: begin
          if (mem_wready) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= FILL_REQ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch_engine.sv
// Directed bench for line_fetch_engine: bus and line-memory models around the
// engine, with hand-derived expected addresses, data and completion latencies.
module tb_line_fetch_engine;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        fetch_gnt;
  logic [1:0]  fetch_cmd;
  logic [1:0]  fetch_tag;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_addr_pre;
  logic        fetch_done;
  logic        mem_ren;
  logic [6:0]  mem_raddr;
  logic [31:0] memRdata;
  logic        mem_wen;
  logic        mem_wready;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wpri;
  logic        bus_rd_req;
  logic        bus_rd_gnt;
  logic [31:0] bus_rd_addr;
  logic        bus_rd_valid;
  logic [31:0] rdBeat;
  logic        bus_wr_req;
  logic        bus_wr_gnt;
  logic [31:0] bus_wr_addr;
  logic [31:0] bus_wr_data;

  line_fetch_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_req      (fetch_req),
    .fetch_gnt      (fetch_gnt),
    .fetch_cmd      (fetch_cmd),
    .fetch_tag      (fetch_tag),
    .fetch_addr     (fetch_addr),
    .fetch_addr_pre (fetch_addr_pre),
    .fetch_done     (fetch_done),
    .mem_ren        (mem_ren),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (memRdata),
    .mem_wen        (mem_wen),
    .mem_wready     (mem_wready),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .mem_wpri       (mem_wpri),
    .bus_rd_req     (bus_rd_req),
    .bus_rd_gnt     (bus_rd_gnt),
    .bus_rd_addr    (bus_rd_addr),
    .bus_rd_valid   (bus_rd_valid),
    .bus_rd_data    (rdBeat),
    .bus_wr_req     (bus_wr_req),
    .bus_wr_gnt     (bus_wr_gnt),
    .bus_wr_addr    (bus_wr_addr),
    .bus_wr_data    (bus_wr_data)
  );

  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int hsCyc = 0;
  int doneCyc = 0;
  int doneCount = 0;
  int activity = 0;
  int holdSeen = 0;
  int holdBad = 0;
  logic [31:0] lineMem [0:127];
  logic [31:0] rdAddrQ [$];
  int          rdCycQ [$];
  logic [31:0] wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  int          wrCycQ [$];
  logic [6:0]  mwAddrQ [$];
  logic [31:0] mwDataQ [$];
  int rdBase, wrBase, mwBase, doneBase, actBase;
  logic        prevRdStall, prevWrStall;
  logic [31:0] prevRdAddr, prevWdata;
  logic [6:0]  prevWaddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line memory: preloaded with a recognisable pattern while reset is low, one-cycle read latency.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) lineMem[i] <= 32'hC0DE_0000 + 32'(i);
    end else begin
      if (mem_ren) memRdata <= lineMem[mem_raddr];
      if (mem_wen && mem_wready) lineMem[mem_waddr] <= mem_wdata;
    end
  end

  // Bus read slave: each granted read returns a beat derived from its address.
  always @(posedge clk) begin
    if (bus_rd_req && bus_rd_gnt) rdBeat <= bus_rd_addr ^ 32'hA5A5_0000;
  end

  // Transaction recorder sampled mid-cycle, plus hold checks on stalled requests.
  always @(negedge clk) begin
    if (bus_rd_req && bus_rd_gnt) begin
      rdAddrQ.push_back(bus_rd_addr);
      rdCycQ.push_back(cyc);
    end
    if (bus_wr_req && bus_wr_gnt) begin
      wrAddrQ.push_back(bus_wr_addr);
      wrDataQ.push_back(bus_wr_data);
      wrCycQ.push_back(cyc);
    end
    if (mem_wen && mem_wready) begin
      mwAddrQ.push_back(mem_waddr);
      mwDataQ.push_back(mem_wdata);
    end
    if (bus_rd_req || bus_wr_req || mem_ren || mem_wen) activity <= activity + 1;
    if (fetch_done) begin
      doneCount <= doneCount + 1;
      doneCyc   <= cyc;
    end
    if (prevRdStall) begin
      holdSeen <= holdSeen + 1;
      if (!(bus_rd_req && bus_rd_addr == prevRdAddr)) holdBad <= holdBad + 1;
    end else if (prevWrStall) begin
      holdSeen <= holdSeen + 1;
      if (!(mem_wen && mem_waddr == prevWaddr && mem_wdata == prevWdata)) holdBad <= holdBad + 1;
    end
    prevRdStall <= rst_n && bus_rd_req && !bus_rd_gnt;
    prevWrStall <= rst_n && mem_wen && !mem_wready;
    prevRdAddr  <= bus_rd_addr;
    prevWaddr   <= mem_waddr;
    prevWdata   <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Issue one fetch command; returns just after the edge that accepts it.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [1:0] tag,
                               input logic [31:0] addr, input logic [31:0] addrPre);
    rdBase   = rdAddrQ.size();
    wrBase   = wrAddrQ.size();
    mwBase   = mwAddrQ.size();
    doneBase = doneCount;
    actBase  = activity;
    fetch_req      = 1'b1;
    fetch_cmd      = cmd;
    fetch_tag      = tag;
    fetch_addr     = addr;
    fetch_addr_pre = addrPre;
    @(negedge clk);
    checkOutput("gnt_before_hs", 64'(fetch_gnt), 64'd1);
    hsCyc = cyc;
    @(posedge clk);
    #1;
    fetch_req      = 1'b0;
    fetch_cmd      = 2'b00;
    fetch_tag      = 2'b00;
    fetch_addr     = 32'h0;
    fetch_addr_pre = 32'h0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (doneCount == doneBase && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (doneCount == doneBase) checkOutput("done_timeout", 64'd0, 64'd1);
    checkOutput("gnt_after_done", 64'(fetch_gnt), 64'd1);
    checkOutput("done_single_cycle", 64'(fetch_done), 64'd0);
    @(negedge clk);
    checkOutput("done_pulses", 64'(doneCount - doneBase), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkFill(input logic [1:0] tag, input logic [31:0] addr, input int latency);
    logic [6:0]  expWaddr;
    logic [31:0] expA;
    checkOutput("done_latency", 64'(doneCyc - hsCyc), 64'(latency));
    checkOutput("rd_count", 64'(rdAddrQ.size() - rdBase), 64'd32);
    checkOutput("mw_count", 64'(mwAddrQ.size() - mwBase), 64'd32);
    for (int k = 0; k < 32; k++) begin
      expA     = addr + 32'(4 * k);
      expWaddr = {tag, 5'(k)};
      if (rdBase + k < rdAddrQ.size())
        checkOutput("rd_addr", 64'(rdAddrQ[rdBase + k]), 64'(expA));
      if (mwBase + k < mwAddrQ.size()) begin
        checkOutput("mw_addr", 64'(mwAddrQ[mwBase + k]), 64'(expWaddr));
        checkOutput("mw_data", 64'(mwDataQ[mwBase + k]), 64'(expA ^ 32'hA5A5_0000));
      end
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({fetch_done, mem_ren, mem_wen, bus_rd_req, bus_wr_req, mem_wpri}), 64'd0);
    checkOutput({tag, "_memaddr"}, 64'({mem_raddr, mem_waddr}), 64'd0);
    checkOutput({tag, "_busaddr"}, {bus_rd_addr, bus_wr_addr}, 64'd0);
    checkOutput({tag, "_data"}, {mem_wdata, bus_wr_data}, 64'd0);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    fetch_req      = 1'b0;
    fetch_cmd      = 2'b00;
    fetch_tag      = 2'b00;
    fetch_addr     = 32'h0;
    fetch_addr_pre = 32'h0;
    mem_wready     = 1'b1;
    bus_rd_gnt     = 1'b1;
    bus_rd_valid   = 1'b1;
    bus_wr_gnt     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("reset");
    checkOutput("reset_gnt", 64'(fetch_gnt), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_gnt", 64'(fetch_gnt), 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] plain fill, tag 2 at 0x1000");
    applyStimulus(2'b01, 2'd2, 32'h1000, 32'h0);
    waitDone(400);
    checkFill(2'd2, 32'h1000, 97);
    checkOutput("fill_no_bus_wr", 64'(wrAddrQ.size() - wrBase), 64'd0);

    $display("[TB] writeback then fill, tag 1");
    applyStimulus(2'b10, 2'd1, 32'h3000, 32'h2000);
    waitDone(600);
    checkFill(2'd1, 32'h3000, 161);
    checkOutput("wb_count", 64'(wrAddrQ.size() - wrBase), 64'd32);
    for (int k = 0; k < 32; k++) begin
      if (wrBase + k < wrAddrQ.size()) begin
        checkOutput("wb_addr", 64'(wrAddrQ[wrBase + k]), 64'(32'h2000 + 32'(4 * k)));
        checkOutput("wb_data", 64'(wrDataQ[wrBase + k]), 64'(32'hC0DE_0000 + 32'(32 + k)));
      end
    end
    if (wrAddrQ.size() > wrBase && rdAddrQ.size() > rdBase)
      checkOutput("wb_before_fill", 64'(wrCycQ[wrAddrQ.size() - 1] < rdCycQ[rdBase]), 64'd1);

    $display("[TB] fill with bus and memory backpressure");
    n = holdSeen;
    bus_rd_gnt = 1'b0;
    applyStimulus(2'b01, 2'd0, 32'h4000, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    bus_rd_gnt = 1'b1;
    for (int t = 0; t < 500; t++) begin
      if (mem_wen && mem_waddr == 7'd7) break;
      @(posedge clk);
      #1;
    end
    checkOutput("stall_word7_wen", 64'({mem_wen, mem_waddr}), 64'({1'b1, 7'd7}));
    checkOutput("stall_wpri", 64'(mem_wpri), 64'd2);
    mem_wready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    mem_wready = 1'b1;
    waitDone(600);
    checkFill(2'd0, 32'h4000, 105);
    checkOutput("hold_seen", 64'(holdSeen - n), 64'd8);
    checkOutput("hold_bad", 64'(holdBad), 64'd0);

    $display("[TB] no-op command");
    applyStimulus(2'b00, 2'd3, 32'h7000, 32'h8000);
    waitDone(20);
    checkOutput("nop_latency", 64'(doneCyc - hsCyc), 64'd1);
    checkOutput("nop_activity", 64'(activity - actBase), 64'd0);

    $display("[TB] reset in the middle of a fill");
    applyStimulus(2'b01, 2'd0, 32'h5000, 32'h0);
    for (int t = 0; t < 500; t++) begin
      if (bus_rd_req && bus_rd_addr == 32'h5028) break;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_at_word10", 64'(bus_rd_addr), 64'h5028);
    rst_n = 1'b0;
    #1;
    checkQuiet("abort");
    checkOutput("abort_gnt", 64'(fetch_gnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("abort_release_gnt", 64'(fetch_gnt), 64'd1);
    checkOutput("abort_no_done", 64'(doneCount - doneBase), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(2'b11, 2'd3, 32'h6000, 32'h0);
    waitDone(400);
    checkFill(2'd3, 32'h6000, 97);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/line_fetch_engine.md
LINE_FETCH_ENGINE -- requirements
Module: line_fetch_engine

Interface
REQ-001 SHALL have parameters: addr_width, default 32, address width; list_depth, default 4, number of cache lines; data_width, default 32, word width; list_width, default 32, words per line.
REQ-002 SHALL have the following ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  line request from write/read controller.
- fetch_gnt  out  1  request accepted.
- fetch_cmd  in  2  01 fill; 10 writeback then fill; 00/11 see REQ-011.
- fetch_tag  in  clog2(list_depth)  cache line slot.
- fetch_addr  in  addr_width  line-aligned fill address.
- fetch_addr_pre  in  addr_width  line-aligned victim (writeback) address.
- fetch_done  out  1  one-cycle completion pulse.
- mem_ren  out  1  line-memory read enable.
- mem_raddr  out  clog2(list_depth)+clog2(list_width)  read address.
- mem_rdata  in  data_width  read data, valid the cycle after mem_ren.
- mem_wen  out  1  line-memory write enable.
- mem_wready  in  1  write accepted.
- mem_waddr  out  clog2(list_depth)+clog2(list_width)  write address.
- mem_wdata  out  data_width  write data.
- mem_wpri  out  2  write priority.
- bus_rd_req  out  1  downstream read request.
- bus_rd_gnt  in  1  read request accepted.
- bus_rd_addr  out  addr_width  read address.
- bus_rd_valid  in  1  read data beat.
- bus_rd_data  in  data_width  read data.
- bus_wr_req  out  1  downstream write request.
- bus_wr_gnt  in  1  write accepted.
- bus_wr_addr  out  addr_width  write address.
- bus_wr_data  out  data_width  write data.

Function
REQ-003 SHALL implement states IDLE, WB_RD, WB_WR, FILL_REQ, FILL_DATA, FILL_WR, DONE.
REQ-004 SHALL drive fetch_gnt = (state==IDLE); a handshake is fetch_req && fetch_gnt.
REQ-005 SHALL latch fetch_cmd, fetch_tag, fetch_addr and fetch_addr_pre on handshake, and clear the word counter (width clog2(list_width)) to 0.
REQ-006 SHALL transition on handshake: IDLE->WB_RD for cmd 10; IDLE->FILL_REQ for cmd 01.
REQ-007 SHALL transition WB_RD->WB_WR unconditionally, asserting mem_ren with mem_raddr={tag,cnt}.
REQ-008 SHALL, in WB_WR, register mem_rdata on entry and hold bus_wr_req=1 with bus_wr_addr=addr_pre+cnt*(data_width/8) and bus_wr_data=captured word until bus_wr_gnt.
REQ-009 SHALL, on bus_wr_gnt: if cnt==list_width-1, clear cnt and go to FILL_REQ; otherwise increment cnt and go to WB_RD.
REQ-010 SHALL cycle per fill word as follows:
- FILL_REQ: assert bus_rd_req with bus_rd_addr=addr+cnt*(data_width/8) until bus_rd_gnt, then go to FILL_DATA.
- FILL_DATA: register bus_rd_data when bus_rd_valid, then go to FILL_WR.
- FILL_WR: assert mem_wen, mem_waddr={tag,cnt}, mem_wdata=registered beat until mem_wready.
- On mem_wready: if cnt==list_width-1 go to DONE; otherwise increment cnt and go to FILL_REQ.
REQ-011 SHALL, for cmd 00, go IDLE->DONE with no memory or bus activity; cmd 11 SHALL behave as 01.
REQ-012 SHALL assert fetch_done exactly one cycle in DONE, then return to IDLE; a new handshake SHALL be possible the following cycle.
REQ-013 SHALL drive mem_wpri=2'b10 in FILL_WR and 2'b00 otherwise.
REQ-014 SHALL drive all request/enable outputs to 0 outside their states; address/data outputs are don't-care when not enabled but SHALL be 0 in IDLE.
REQ-015 SHALL ignore bus_rd_valid outside FILL_DATA, and bus/mem grants outside their requesting states.
REQ-016 SHALL compute address arithmetic modulo 2^addr_width; the counter SHALL never exceed list_width-1.

Reset
REQ-017 SHALL, on rst_n low at any time including mid-line: state=IDLE; counter, latched fields and data registers=0; all outputs 0 except fetch_gnt=1 once rst_n is released; no partial completion pulse.

Structure
REQ-018 SHALL place the state enum and fetch_cmd encodings (FETCH_NOP=00, FETCH_FILL=01, FETCH_WB_FILL=10) in shared package cache_pkg.
REQ-019 SHALL be a single module with no sub-module.

Verification
REQ-020 Bench SHALL cover the following directed scenarios (defaults, all grants/valid/wready tied 1):
- Fill, cmd 01, tag 2, addr 0x1000 -> 32 bus reads at 0x1000..0x107C; mem writes at waddr 64..95; fetch_done exactly 97 cycles after the handshake cycle.
- Writeback+fill, cmd 10, tag 1, addr_pre 0x2000, addr 0x3000, preloaded line -> 32 bus writes at 0x2000..0x207C carrying mem words 32..63 in order, all before the first bus read at 0x3000; then the fill as above.
- Backpressure: mem_wready low 5 cycles on word 7, bus_rd_gnt low 3 cycles on word 0 -> mem_wen/bus_rd_req held with stable address/data, no word lost or duplicated.
- cmd 00 -> fetch_done 1 cycle after the handshake; no bus_*_req or mem_* enables.
- Reset asserted during word 10 of a fill -> all outputs 0 immediately; after release fetch_gnt=1, and a new fill completes correctly from word 0.
